// File: rtl/vga_rx_monitor_pkg.sv
// Shared 640x480@60 VGA timing constants and monitor state encoding.
// Used by the receive monitor and by the VGA generator.
package vga_rx_monitor_pkg;

    localparam int VGA_CLK_DIV  = 4;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = 800;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = 525;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } mon_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/vga_rx_monitor_edge_det.sv
// Two-register sync edge detector: first stage is the registered input,
// edges are flagged by comparing it against the second stage.
module vga_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic fall,
    output logic rise
);

    logic s_q;
    logic d_q;

    // Syncs idle high, so reset to 1 to avoid a spurious edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q <= 1'b1;
            d_q <= 1'b1;
        end else begin
            s_q <= din;
            d_q <= s_q;
        end
    end

    assign fall = d_q & ~s_q;
    assign rise = ~d_q & s_q;

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA receive-side timing monitor: checks line/frame timing, locks onto a
// clean stream and samples one pixel per frame at a programmable position.
//   state      | meaning
//   ST_SEARCH  | waiting for the first vsync; nothing is checked
//   ST_MEASURE | checking timing, waiting for one error-free frame
//   ST_LOCKED  | timing verified; pixel capture enabled
module vga_rx_monitor
    import vga_rx_monitor_pkg::*;
#(
    parameter int CLK_DIV  = VGA_CLK_DIV,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int H_TOTAL  = VGA_H_TOTAL,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int V_TOTAL  = VGA_V_TOTAL
) (
    input  logic        clk_100m,
    input  logic        rst,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    input  logic [2:0]  vga_r,
    input  logic [2:0]  vga_g,
    input  logic [1:0]  vga_b,
    input  logic [9:0]  cap_x,
    input  logic [8:0]  cap_y,
    output logic        locked,
    output logic [7:0]  h_err_cnt,
    output logic [7:0]  v_err_cnt,
    output logic [15:0] frame_cnt,
    output logic        cap_valid,
    output logic [7:0]  cap_pixel
);

    localparam logic [12:0] LINE_CYC    = 13'(H_TOTAL * CLK_DIV);
    localparam logic [12:0] HSYNC_CYC   = 13'(H_SYNC * CLK_DIV);
    localparam logic [10:0] FRAME_LINES = 11'(V_TOTAL);
    localparam logic [10:0] VSYNC_LINES = 11'(V_SYNC);
    // Inconsistent timing parameters make the capture position meaningless.
    localparam logic TIMING_OK = (H_ACTIVE + H_FP + H_SYNC + H_BP == H_TOTAL) &&
                                 (V_ACTIVE + V_FP + V_SYNC + V_BP == V_TOTAL);

    mon_state_t  state_q, state_d;
    logic        hs_fall, hs_rise, vs_fall, vs_rise;
    logic [7:0]  rgb_s;
    logic [11:0] hcnt;
    logic [9:0]  vline;
    logic [9:0]  cap_x_l;
    logic [8:0]  cap_y_l;
    logic        h_armed;
    logic        frame_err;
    logic [12:0] hcnt_p1;
    logic [10:0] vline_p1;
    logic [15:0] cap_h_tgt;
    logic [10:0] cap_v_tgt;
    logic        checking, h_err, v_err, cap_in_range, cap_hit;

    vga_edge_det u_hs_edge (
        .clk  (clk_100m),
        .rst  (rst),
        .din  (vga_hsync),
        .fall (hs_fall),
        .rise (hs_rise)
    );

    vga_edge_det u_vs_edge (
        .clk  (clk_100m),
        .rst  (rst),
        .din  (vga_vsync),
        .fall (vs_fall),
        .rise (vs_rise)
    );

    // vline+1 is the number of hsync falls since vsync fell, so it measures
    // both the frame length and the sync length.
    assign hcnt_p1  = {1'b0, hcnt} + 13'd1;
    assign vline_p1 = {1'b0, vline} + 11'd1;
    assign checking = (state_q != ST_SEARCH);

    assign h_err = checking &&
                   ((hs_fall && h_armed && (hcnt_p1 != LINE_CYC)) ||
                    (hs_rise && (hcnt_p1 != HSYNC_CYC)));
    assign v_err = checking &&
                   ((vs_fall && (vline_p1 != FRAME_LINES)) ||
                    (vs_rise && (vline_p1 != VSYNC_LINES)));

    assign cap_h_tgt = (16'(H_SYNC + H_BP) + {6'd0, cap_x_l}) * 16'(CLK_DIV)
                       + 16'(CLK_DIV / 2);
    assign cap_v_tgt = 11'(V_SYNC + V_BP) + {2'd0, cap_y_l};
    assign cap_in_range = ({1'b0, cap_x_l} < 11'(H_ACTIVE)) &&
                          ({1'b0, cap_y_l} < 10'(V_ACTIVE));
    assign cap_hit = TIMING_OK && (state_q == ST_LOCKED) && cap_in_range &&
                     ({1'b0, vline} == cap_v_tgt) && ({4'd0, hcnt} == cap_h_tgt);

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) state_q <= ST_SEARCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SEARCH:  if (vs_fall) state_d = ST_MEASURE;
            ST_MEASURE: if (vs_fall && !frame_err && !h_err && !v_err) state_d = ST_LOCKED;
            ST_LOCKED:  if (h_err || v_err) state_d = ST_MEASURE;
            default:    state_d = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            rgb_s     <= 8'd0;
            hcnt      <= 12'd0;
            vline     <= 10'd0;
            cap_x_l   <= 10'd0;
            cap_y_l   <= 9'd0;
            h_armed   <= 1'b0;
            frame_err <= 1'b0;
            locked    <= 1'b0;
            h_err_cnt <= 8'd0;
            v_err_cnt <= 8'd0;
            frame_cnt <= 16'd0;
            cap_valid <= 1'b0;
            cap_pixel <= 8'd0;
        end else begin
            rgb_s <= {vga_r, vga_g, vga_b};

            if (hs_fall)            hcnt <= 12'd0;
            else if (hcnt != '1)    hcnt <= hcnt + 12'd1;

            if (vs_fall)            vline <= hs_fall ? 10'd0 : 10'h3FF;
            else if (hs_fall)       vline <= vline + 10'd1;

            if (vs_fall) begin
                cap_x_l   <= cap_x;
                cap_y_l   <= cap_y;
                frame_cnt <= frame_cnt + 16'd1;
            end

            // The first line after leaving SEARCH may be partial.
            if (!checking)          h_armed <= 1'b0;
            else if (hs_fall)       h_armed <= 1'b1;

            if (!checking || vs_fall)   frame_err <= 1'b0;
            else if (h_err || v_err)    frame_err <= 1'b1;

            if (h_err) h_err_cnt <= sat_inc8(h_err_cnt);
            if (v_err) v_err_cnt <= sat_inc8(v_err_cnt);

            locked    <= (state_d == ST_LOCKED);
            cap_valid <= cap_hit;
            if (cap_hit) cap_pixel <= rgb_s;
        end
    end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Bench for vga_rx_monitor with a scaled-down timing set and a scoreboard
// of expected captured pixels.
module tb_vga_rx_monitor;

    localparam int CLK_DIV  = 4;
    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 4;
    localparam int H_BP     = 4;
    localparam int H_TOTAL  = 26;
    localparam int V_ACTIVE = 8;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int V_TOTAL  = 14;
    localparam int LINE_CYC = H_TOTAL * CLK_DIV;
    localparam int HS_CYC   = H_SYNC * CLK_DIV;
    localparam int H_START  = H_SYNC + H_BP;
    localparam int V_START  = V_SYNC + V_BP;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vga_hsync = 1'b1;
    logic        vga_vsync = 1'b1;
    logic [2:0]  vga_r = '0;
    logic [2:0]  vga_g = '0;
    logic [1:0]  vga_b = '0;
    logic [9:0]  cap_x = '0;
    logic [8:0]  cap_y = '0;
    logic        locked;
    logic [7:0]  h_err_cnt;
    logic [7:0]  v_err_cnt;
    logic [15:0] frame_cnt;
    logic        cap_valid;
    logic [7:0]  cap_pixel;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_caps   = 0;
    logic [7:0]  sb_q[$];
    bit          solid = 1'b0;
    int          cx_m = 0;
    int          cy_m = 0;
    logic [7:0]  h_prev = 8'd0;

    vga_rx_monitor #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC),
        .H_BP(H_BP), .H_TOTAL(H_TOTAL), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP),
        .V_SYNC(V_SYNC), .V_BP(V_BP), .V_TOTAL(V_TOTAL)
    ) dut (
        .clk_100m  (clk),
        .rst       (rst),
        .vga_hsync (vga_hsync),
        .vga_vsync (vga_vsync),
        .vga_r     (vga_r),
        .vga_g     (vga_g),
        .vga_b     (vga_b),
        .cap_x     (cap_x),
        .cap_y     (cap_y),
        .locked    (locked),
        .h_err_cnt (h_err_cnt),
        .v_err_cnt (v_err_cnt),
        .frame_cnt (frame_cnt),
        .cap_valid (cap_valid),
        .cap_pixel (cap_pixel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int x, input int y);
        return {x[2:0], y[2:0], x[3], ~y[0]};
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_cap_valid"}, cap_valid, 0);
        chk({tag, "_cap_pixel"}, cap_pixel, 0);
        chk({tag, "_h_err"}, h_err_cnt, 0);
        chk({tag, "_v_err"}, v_err_cnt, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    // One line: hsync falls at cycle 0, vsync level fixed for the line.
    task automatic drive_line(input int len, input bit vs, input int line,
                              input bit cap_en, input int rst_at);
        for (int c = 0; c < len; c++) begin
            int p;
            bit act;
            logic [7:0] col;
            @(negedge clk);
            p   = c / CLK_DIV;
            act = (p >= H_START) && (p < H_START + H_ACTIVE) &&
                  (line >= V_START) && (line < V_START + V_ACTIVE);
            col = !act ? 8'h00 : (solid ? 8'hE0 : pix(p - H_START, line - V_START));
            vga_hsync = (c >= HS_CYC);
            vga_vsync = !vs;
            {vga_r, vga_g, vga_b} = col;
            if (cap_en && act && (c % CLK_DIV == 0) && cx_m < H_ACTIVE && cy_m < V_ACTIVE &&
                (p - H_START == cx_m) && (line - V_START == cy_m))
                sb_q.push_back(col);
            if (rst_at >= 0 && c == rst_at) rst = 1'b1;
            if (rst_at >= 0 && c == rst_at + 2) chk_all_zero("midrst");
            if (rst_at >= 0 && c == rst_at + 3) rst = 1'b0;
        end
    endtask

    task automatic drive_frame(input int lines, input int bad_line, input int bad_len,
                               input bit cap_en, input int rst_line);
        cx_m = int'(cap_x);
        cy_m = int'(cap_y);
        for (int l = 0; l < lines; l++)
            drive_line((l == bad_line) ? bad_len : LINE_CYC, l < V_SYNC, l, cap_en,
                       (l == rst_line) ? 20 : -1);
    endtask

    always @(negedge clk) begin
        if (cap_valid) begin
            n_caps++;
            chk("cap_expected", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) chk("cap_pixel", cap_pixel, sb_q.pop_front());
        end
        if (h_err_cnt != h_prev && h_err_cnt == 8'd1)
            chk("lock_drop_same_cycle", locked, 0);
        h_prev = h_err_cnt;
    end

    initial begin
        #35;
        chk_all_zero("reset");
        #65;
        rst = 1'b0;
        repeat (8) @(negedge clk);

        cap_x = 10'd3; cap_y = 9'd2; solid = 1'b0;
        drive_frame(V_TOTAL, -1, 0, 1'b0, -1);
        chk("f1_locked", locked, 0);
        chk("f1_frame_cnt", frame_cnt, 1);
        drive_frame(V_TOTAL, -1, 0, 1'b1, -1);
        chk("f2_locked", locked, 1);
        chk("f2_frame_cnt", frame_cnt, 2);
        chk("f2_h_err", h_err_cnt, 0);
        chk("f2_v_err", v_err_cnt, 0);
        drive_frame(V_TOTAL, -1, 0, 1'b1, -1);
        chk("f3_frame_cnt", frame_cnt, 3);
        chk("f3_locked", locked, 1);

        cap_x = 10'd0; cap_y = 9'd0; solid = 1'b1;
        drive_frame(V_TOTAL, -1, 0, 1'b1, -1);
        chk("solid_pixel", cap_pixel, 8'hE0);
        cap_x = 10'(H_ACTIVE);
        drive_frame(V_TOTAL, -1, 0, 1'b1, -1);
        chk("x_oob_hold", cap_pixel, 8'hE0);
        chk("x_oob_locked", locked, 1);
        cap_x = 10'd0; cap_y = 9'(V_ACTIVE); solid = 1'b0;
        drive_frame(V_TOTAL, -1, 0, 1'b1, -1);
        chk("y_oob_hold", cap_pixel, 8'hE0);
        cap_x = 10'(H_ACTIVE - 1); cap_y = 9'(V_ACTIVE - 1);
        drive_frame(V_TOTAL, -1, 0, 1'b1, -1);

        drive_frame(V_TOTAL, 6, LINE_CYC - 4, 1'b0, -1);
        chk("short_line_h_err", h_err_cnt, 1);
        chk("short_line_v_err", v_err_cnt, 0);
        chk("short_line_locked", locked, 0);
        drive_frame(V_TOTAL, -1, 0, 1'b0, -1);
        chk("relock_wait", locked, 0);
        drive_frame(V_TOTAL, -1, 0, 1'b1, -1);
        chk("relock", locked, 1);
        chk("relock_h_err", h_err_cnt, 1);

        drive_frame(V_TOTAL - 1, -1, 0, 1'b1, -1);
        drive_frame(V_TOTAL, -1, 0, 1'b0, -1);
        chk("short_frame_v_err", v_err_cnt, 1);
        chk("short_frame_h_err", h_err_cnt, 1);
        chk("short_frame_locked", locked, 0);
        chk("frame_cnt_12", frame_cnt, 12);

        for (int f = 0; f < 130; f++) begin
            drive_line(40, 1'b1, 0, 1'b0, -1);
            drive_line(40, 1'b0, 1, 1'b0, -1);
        end
        drive_frame(V_TOTAL, -1, 0, 1'b0, -1);
        chk("sat_h_err", h_err_cnt, 255);
        chk("sat_v_err", v_err_cnt, 255);
        chk("sat_locked", locked, 0);

        drive_frame(V_TOTAL, V_TOTAL - 1, 50, 1'b0, 6);
        chk("post_rst_frame_cnt", frame_cnt, 0);
        chk("post_rst_h_err", h_err_cnt, 0);
        drive_frame(V_TOTAL, -1, 0, 1'b0, -1);
        chk("rst_fa_frame_cnt", frame_cnt, 1);
        chk("rst_fa_locked", locked, 0);
        chk("rst_fa_h_err", h_err_cnt, 0);
        chk("rst_fa_v_err", v_err_cnt, 0);
        drive_frame(V_TOTAL, -1, 0, 1'b1, -1);
        chk("rst_fb_frame_cnt", frame_cnt, 2);
        chk("rst_fb_locked", locked, 1);
        chk("rst_fb_h_err", h_err_cnt, 0);
        chk("rst_fb_v_err", v_err_cnt, 0);

        @(negedge clk);
        vga_hsync = 1'b1;
        vga_vsync = 1'b1;
        repeat (20) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        chk("cap_count", n_caps, 7);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
